// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
// The master side drives the operands and out_ready. The slave side is the divider.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring unsigned divider: one quotient bit per BUSY cycle, MSB first.
// Define SEQ_DIVIDER_ZERO_SHORTCUT_EN to send zero-divisor operations straight from IDLE to DONE.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] quo_q;
    logic             dbz_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic             ge;

    // The kept remainder is always below the divisor, so the W-bit difference is exact when ge.
    always_comb begin
        shifted = {rem_q, dvd_q[WIDTH-1]};
        ge      = (shifted >= {1'b0, dsr_q});
        trial   = shifted[WIDTH-1:0] - dsr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
`ifdef SEQ_DIVIDER_ZERO_SHORTCUT_EN
                    state_d = (bus.divisor == '0) ? DONE : BUSY;
`else
                    state_d = BUSY;
`endif
                end
            end
            BUSY: begin
                if (count_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        rem_q   <= '0;
                        dvd_q   <= bus.dividend;
                        dsr_q   <= bus.divisor;
                        quo_q   <= '0;
                        count_q <= CW'(WIDTH - 1);
                        dbz_q   <= (bus.divisor == '0);
`ifdef SEQ_DIVIDER_ZERO_SHORTCUT_EN
                        if (bus.divisor == '0) begin
                            quo_q <= '1;
                            rem_q <= bus.dividend;
                        end
`endif
                    end
                end
                BUSY: begin
                    rem_q <= ge ? trial : shifted[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], ge};
                    dvd_q <= dvd_q << 1;
                    if (count_q != '0) begin
                        count_q <= count_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.in_ready    = (state_q == IDLE);
        bus.out_valid   = (state_q == DONE);
        bus.quotient    = quo_q;
        bus.remainder   = rem_q;
        bus.div_by_zero = dbz_q;
    end
endmodule

// File: tb/tb_seq_divider.sv
// Directed and random-operand bench for seq_divider at WIDTH=8.
// It follows SEQ_DIVIDER_ZERO_SHORTCUT_EN for the expected zero-divisor latency.
module tb_seq_divider;
    localparam int unsigned W = 8;
`ifdef SEQ_DIVIDER_ZERO_SHORTCUT_EN
    localparam int ZLAT = 0;
`else
    localparam int ZLAT = 8;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // Operands are scrambled after the accepting edge so late sampling would corrupt results.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, output int lat);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            tick();
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.in_valid = 1'b0;
        bus.dividend = 8'($urandom);
        bus.divisor  = 8'($urandom);
        wait_result(lat);
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: rdy=%0b vld=%0b q=%0d r=%0d dbz=%0b, required rdy=1 vld=0 q=0 r=0 dbz=0",
                     bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        issue(8'd100, 8'd7, lat);
        vectors++;
        if (lat !== 8) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d, required 8", lat);
        end
        vectors++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {8'd14, 8'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL basic_100_7: q=%0d r=%0d dbz=%0b, required q=14 r=2 dbz=0",
                     bus.quotient, bus.remainder, bus.div_by_zero);
        end
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_ready_in_done: got %0b, required 0", bus.in_ready);
        end
        retire();
        vectors++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL basic_retire: rdy=%0b vld=%0b, required rdy=1 vld=0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_ignore();
        bus.in_valid = 1'b0;
        bus.dividend = 8'd9;
        bus.divisor  = 8'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
                miscompares++;
                $display("FAIL ignore_cycle%0d: rdy=%0b vld=%0b, required rdy=1 vld=0", i, bus.in_ready, bus.out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(8'd255, 8'd1, lat);
        vectors++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {8'd255, 8'd0, 1'b0} || lat !== 8) begin
            miscompares++;
            $display("FAIL b2b_255_1: q=%0d r=%0d dbz=%0b lat=%0d, required q=255 r=0 dbz=0 lat=8",
                     bus.quotient, bus.remainder, bus.div_by_zero, lat);
        end
        // Next operation is already offered on the retiring edge; it must not be taken there.
        bus.in_valid  = 1'b1;
        bus.dividend  = 8'd3;
        bus.divisor   = 8'd200;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        vectors++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_no_accept_on_retire: rdy=%0b vld=%0b, required rdy=1 vld=0", bus.in_ready, bus.out_valid);
        end
        tick();
        bus.in_valid = 1'b0;
        wait_result(lat);
        vectors++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {8'd0, 8'd3, 1'b0} || lat !== 8) begin
            miscompares++;
            $display("FAIL b2b_3_200: q=%0d r=%0d dbz=%0b lat=%0d, required q=0 r=3 dbz=0 lat=8",
                     bus.quotient, bus.remainder, bus.div_by_zero, lat);
        end
        retire();
    endtask

    task automatic test_div_by_zero();
        int lat;
        issue(8'd77, 8'd0, lat);
        vectors++;
        if (lat !== ZLAT) begin
            miscompares++;
            $display("FAIL dbz_latency: got %0d, required %0d", lat, ZLAT);
        end
        vectors++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {8'd255, 8'd77, 1'b1}) begin
            miscompares++;
            $display("FAIL dbz_77_0: q=%0d r=%0d dbz=%0b, required q=255 r=77 dbz=1",
                     bus.quotient, bus.remainder, bus.div_by_zero);
        end
        retire();
        issue(8'd0, 8'd0, lat);
        vectors++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {8'd255, 8'd0, 1'b1} || lat !== ZLAT) begin
            miscompares++;
            $display("FAIL dbz_0_0: q=%0d r=%0d dbz=%0b lat=%0d, required q=255 r=0 dbz=1 lat=%0d",
                     bus.quotient, bus.remainder, bus.div_by_zero, lat, ZLAT);
        end
        retire();
    endtask

    task automatic test_stall();
        int lat;
        issue(8'd50, 8'd6, lat);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.dividend = 8'($urandom);
            bus.divisor  = 8'($urandom);
            tick();
            vectors++;
            if ({bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, 1'b0, 8'd8, 8'd2, 1'b0}) begin
                miscompares++;
                $display("FAIL stall_hold%0d: vld=%0b rdy=%0b q=%0d r=%0d dbz=%0b, required vld=1 rdy=0 q=8 r=2 dbz=0",
                         i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.div_by_zero);
            end
        end
        bus.in_valid = 1'b0;
        retire();
        vectors++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL stall_release: vld=%0b rdy=%0b, required vld=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        tick();
        vectors++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL stall_nothing_accepted: vld=%0b rdy=%0b, required vld=0 rdy=1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_abort();
        int   lat;
        logic seen;
        bus.in_valid = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 8'd3;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL abort_reset_values: rdy=%0b vld=%0b q=%0d r=%0d dbz=%0b, required rdy=1 vld=0 q=0 r=0 dbz=0",
                     bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_out_valid: saw out_valid=%0b, required 0", seen);
        end
        issue(8'd200, 8'd3, lat);
        vectors++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {8'd66, 8'd2, 1'b0} || lat !== 8) begin
            miscompares++;
            $display("FAIL abort_then_200_3: q=%0d r=%0d dbz=%0b lat=%0d, required q=66 r=2 dbz=0 lat=8",
                     bus.quotient, bus.remainder, bus.div_by_zero, lat);
        end
        retire();
    endtask

    task automatic test_random();
        int          lat, exp_lat, stall;
        logic [7:0]  a, b, eq, er;
        logic        ez;
        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 5))
                0:       a = 8'd0;
                1:       a = 8'd255;
                default: a = 8'($urandom);
            endcase
            case ($urandom_range(0, 6))
                0:       b = 8'd0;
                1:       b = 8'd1;
                2:       b = 8'd255;
                default: b = 8'($urandom);
            endcase
            if (b == 8'd0) begin
                eq = 8'd255; er = a; ez = 1'b1; exp_lat = ZLAT;
            end else begin
                eq = a / b; er = a % b; ez = 1'b0; exp_lat = 8;
            end
            issue(a, b, lat);
            vectors++;
            if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {eq, er, ez} || lat !== exp_lat) begin
                miscompares++;
                $display("FAIL rand_%0d_%0d: q=%0d r=%0d dbz=%0b lat=%0d, required q=%0d r=%0d dbz=%0b lat=%0d",
                         a, b, bus.quotient, bus.remainder, bus.div_by_zero, lat, eq, er, ez, exp_lat);
            end
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) tick();
            vectors++;
            if ({bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b1, eq, er, ez}) begin
                miscompares++;
                $display("FAIL rand_hold_%0d_%0d: vld=%0b q=%0d r=%0d dbz=%0b after %0d stalls",
                         a, b, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero, stall);
            end
            retire();
            vectors++;
            if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
                miscompares++;
                $display("FAIL rand_retire_%0d_%0d: vld=%0b rdy=%0b, required vld=0 rdy=1", a, b, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_ignore();
        test_back_to_back();
        test_div_by_zero();
        test_stall();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
